// File: rtl/reg_en_pipe_if.sv
// Bundles the enable/data signals of one reg_en_pipe instance so a bench or
// parent can wire a pipe as a unit; clk and reset stay outside the bundle.
interface reg_en_pipe_if #(
    parameter int WIDTH = 2
);
    logic             enable;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    modport master (output enable, output din, input  dout);
    modport slave  (input  enable, input  din, output dout);
endinterface

// File: rtl/reg_en_pipe.sv
// Clock-enabled register chain of STAGES stages; out is the last stage.
// Latency STAGES enabled edges; enable=0 freezes every stage (no bubbles), async reset loads RESET_VALUE.
module reg_en_pipe #(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    generate
        if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
            $error("reg_en_pipe: STAGES must be in 1..8");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // All stages shift together on an enabled edge, otherwise hold as a block.
    always_comb begin
        stage_d = stage_q;
        if (enable) begin
            stage_d[0] = in;
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out = stage_q[STAGES-1];

endmodule

// File: tb/tb_reg_en_pipe.sv
// Scoreboard bench for reg_en_pipe: three configurations share clk/reset,
// stimulus pushes expected outputs, a monitor process pops and compares them.
module tb_reg_en_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_en_pipe_if #(.WIDTH(2)) ia ();
    reg_en_pipe_if #(.WIDTH(2)) ib ();
    reg_en_pipe_if #(.WIDTH(8)) ic ();

    reg_en_pipe #(.WIDTH(2), .RESET_VALUE(2'b00), .STAGES(1)) u_a (
        .clk(clk), .reset(rst), .enable(ia.enable), .in(ia.din), .out(ia.dout)
    );
    reg_en_pipe #(.WIDTH(2), .RESET_VALUE(2'b10), .STAGES(1)) u_b (
        .clk(clk), .reset(rst), .enable(ib.enable), .in(ib.din), .out(ib.dout)
    );
    reg_en_pipe #(.WIDTH(8), .RESET_VALUE(8'h00), .STAGES(3)) u_c (
        .clk(clk), .reset(rst), .enable(ic.enable), .in(ic.din), .out(ic.dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         q_dut  [$];
    logic [7:0] q_exp  [$];
    string      q_name [$];
    event       mon_ev;

    task automatic push(input int d, input logic [7:0] e, input string n);
        q_dut.push_back(d);
        q_exp.push_back(e);
        q_name.push_back(n);
    endtask

    task automatic exp_ab(input logic [1:0] a, input logic [1:0] b, input string n);
        push(0, {6'b0, a}, {n, "_a"});
        push(1, {6'b0, b}, {n, "_b"});
    endtask

    task automatic drive_ab(input logic en, input logic [1:0] d);
        ia.enable = en;
        ia.din    = d;
        ib.enable = en;
        ib.din    = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are compared away from the rising edge.
    initial begin : monitor
        int         d;
        logic [7:0] e;
        logic [7:0] act;
        string      n;
        forever begin
            @(negedge clk or mon_ev);
            while (q_dut.size() > 0) begin
                d = q_dut.pop_front();
                e = q_exp.pop_front();
                n = q_name.pop_front();
                case (d)
                    0:       act = {6'b0, ia.dout};
                    1:       act = {6'b0, ib.dout};
                    default: act = ic.dout;
                endcase
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: out=%0h required %0h", n, act, e);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        drive_ab(1'b1, 2'b00);
        ic.enable = 1'b1;
        ic.din    = 8'hAA;
        #1;
        exp_ab(2'b00, 2'b10, "rst_init");
        push(2, 8'h00, "rst_init_c");

        for (int i = 0; i < 4; i++) begin
            drive_ab(1'b1, 2'(i));
            step;
            exp_ab(2'b00, 2'b10, "rst_hold");
        end
        push(2, 8'h00, "rst_hold_c");

        // Release and capture
        rst       = 1'b0;
        ic.enable = 1'b0;
        drive_ab(1'b1, 2'b01);
        step;
        exp_ab(2'b01, 2'b01, "cap1");
        drive_ab(1'b1, 2'b10);
        step;
        exp_ab(2'b10, 2'b10, "cap2");
        push(2, 8'h00, "c_idle");

        // Asynchronous clear between edges, checked before the next edge
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_ab(2'b00, 2'b10, "async_clr");
        -> mon_ev;
        #1;
        rst = 1'b0;
        step;
        exp_ab(2'b10, 2'b10, "post_clr_cap");

        // Hold
        drive_ab(1'b0, 2'b11);
        step;
        exp_ab(2'b10, 2'b10, "hold1");
        drive_ab(1'b0, 2'b10);
        step;
        exp_ab(2'b10, 2'b10, "hold2");
        drive_ab(1'b0, 2'b00);
        step;
        exp_ab(2'b10, 2'b10, "hold3");
        drive_ab(1'b1, 2'b01);
        step;
        exp_ab(2'b01, 2'b01, "reenable");

        // Reset asserted in the same time step as an enabled edge
        drive_ab(1'b1, 2'b11);
        @(posedge clk);
        rst = 1'b1;
        #1;
        exp_ab(2'b00, 2'b10, "rst_prio");
        step;
        exp_ab(2'b00, 2'b10, "rst_prio_hold");
        rst = 1'b0;
        drive_ab(1'b0, 2'b11);
        step;
        exp_ab(2'b00, 2'b10, "rel_no_en");
        drive_ab(1'b1, 2'b11);
        step;
        exp_ab(2'b11, 2'b11, "rel_first_cap");

        // Three-stage, 8-bit pipe
        ic.enable = 1'b1;
        ic.din    = 8'h11;
        step;
        push(2, 8'h00, "c_edge1");
        ic.din = 8'h22;
        step;
        push(2, 8'h00, "c_edge2");
        ic.din = 8'h33;
        step;
        push(2, 8'h11, "c_edge3");
        ic.enable = 1'b0;
        ic.din    = 8'h44;
        step;
        push(2, 8'h11, "c_hold");
        ic.enable = 1'b1;
        ic.din    = 8'h55;
        step;
        push(2, 8'h22, "c_resume1");
        ic.din = 8'h66;
        step;
        push(2, 8'h33, "c_resume2");

        // Mid-flight reset discards everything in the chain
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        push(2, 8'h00, "c_async_clr");
        -> mon_ev;
        #1;
        rst    = 1'b0;
        ic.din = 8'h77;
        step;
        push(2, 8'h00, "c_refill1");
        ic.din = 8'h88;
        step;
        push(2, 8'h00, "c_refill2");
        ic.din = 8'h99;
        step;
        push(2, 8'h77, "c_refill3");

        for (int k = 0; k < 10 && q_dut.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (q_dut.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q_dut.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
